axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
Parameters:
REQ-001 SHALL provide parameter DEPTH_WORDS, default 4096: number of 32-bit words in backing memory.
REQ-002 SHALL provide parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.

Ports (name, direction, width, meaning):
REQ-003 SHALL provide port aclk, input, 1: sole clock; all logic rising-edge.
REQ-004 SHALL provide port aresetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL provide the AR channel: arid in 4, araddr in 32, arlen in 8, arsize in 3, arburst in 2, arvalid in 1, arready out 1.
REQ-006 SHALL provide the R channel: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
REQ-007 SHALL provide the AW channel: awid in 4, awaddr in 32, awlen in 8, awsize in 3, awburst in 2, awvalid in 1, awready out 1.
REQ-008 SHALL provide the W channel: wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1.
REQ-009 SHALL provide the B channel: bid out 4, bresp out 2, bvalid out 1, bready in 1.
REQ-010 SHALL accept arlock/awlock (2), arcache/awcache (4) and arprot/awprot (3) as inputs and ignore them; wid SHALL also be ignored.

Function
REQ-011 SHALL run independent read and write engines, each with exactly one burst outstanding; no interleaving.
REQ-012 Read FSM states: R_IDLE, R_DATA. arready = 1 only in R_IDLE; arvalid&&arready latches id/addr/len/size/burst, then goes to R_DATA.
REQ-013 SHALL assert the first rvalid exactly 1 cycle after AR acceptance (registered memory read).
REQ-014 Each rvalid&&rready SHALL complete one beat; the next beat SHALL be valid on the following cycle, giving 1 beat/cycle throughput.
REQ-015 While rvalid && !rready, rdata/rid/rresp/rlast SHALL hold stable.
REQ-016 rlast SHALL be 1 on beat arlen (beats numbered from 0); its handshake SHALL return the FSM to R_IDLE.
REQ-017 Beat address: burst 2'b00 (FIXED) keeps the address; 2'b01 (INCR) adds 1<<size; 2'b10 (WRAP) and 2'b11 SHALL behave as INCR; the add wraps modulo 2^32.
REQ-018 A beat is in range when (addr - BASE_ADDR) < DEPTH_WORDS*4. Index = (addr - BASE_ADDR)>>2; addr[1:0] ignored for indexing.
REQ-019 Out-of-range read beat SHALL return rdata = 0 and rresp = 2'b10 (SLVERR); in-range returns OKAY (2'b00).
REQ-020 Write FSM states: W_IDLE, W_DATA, W_RESP. awready = 1 only in W_IDLE; wready = 1 only in W_DATA; bvalid = 1 only in W_RESP.
REQ-021 Each wvalid&&wready beat SHALL write only the bytes whose wstrb bit is set, same clock edge; out-of-range beats SHALL write nothing.
REQ-022 The write burst SHALL end on beat awlen regardless of wlast, then enter W_RESP.
REQ-023 bresp SHALL be SLVERR if any beat was out of range, or if wlast ≠ (beat==awlen) on any beat; otherwise OKAY. bid = latched awid.
REQ-024 bvalid&&bready SHALL return the FSM to W_IDLE; a new AW SHALL be accepted no earlier than the next cycle.
REQ-025 Same-word read and write in the same cycle SHALL return the old data (read-before-write).
REQ-026 AR and AW presented in the same cycle SHALL both be accepted when both engines are idle.

Reset
REQ-027 aresetn low SHALL immediately force both FSMs to idle: arready=1, awready=1, wready=0, rvalid=0, bvalid=0, rlast=0, rid=bid=0, rresp=bresp=0, rdata=0.
REQ-028 Reset mid-burst SHALL abandon the burst with no response issued; memory contents SHALL NOT be reset.

Structure
REQ-029 A shared package SHALL hold burst type constants (FIXED/INCR/WRAP), resp constants (OKAY=2'b00, SLVERR=2'b10) and both FSM state enums.
REQ-030 Backing store SHALL be a sub-module sram_word_mem: 1 write port with byte enables, 1 registered read port with read enable, no reset.

Verification
REQ-031 AR single beat addr 0x10, len 0 after word 4 = 0xDEADBEEF -> rvalid 1 cycle later, rdata 0xDEADBEEF, rlast=1, rresp=0, rid echoed.
REQ-032 INCR write len 3 at 0x100 with data 1..4 and wstrb F, then INCR read len 3 -> 4 beats 1,2,3,4; rlast only on the 4th beat; bresp=0.
REQ-033 Read burst with rready toggled 1,0,0,1 -> outputs stable during stall; no beat lost or duplicated.
REQ-034 Write 0xAABBCCDD with wstrb 4'b0101 over 0 -> readback 0x00BB00DD.
REQ-035 Read at BASE_ADDR + DEPTH_WORDS*4 -> rresp=2'b10, rdata=0; write there -> bresp=2'b10 and memory unchanged.
REQ-036 aresetn low during beat 2 of a len-7 read -> rvalid drops the same cycle, arready=1; a new AR after release completes normally.

Source files
------------

// File: rtl/axi_sram_slave_pkg.sv
// Shared definitions for the AXI SRAM slave.
//   - AXI burst type and response codes
//   - read and write engine state enums
//   - beat address stepping helper
package axi_sram_slave_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_e;

   // FIXED holds the address. Every other burst type, WRAP included,
   // steps by the transfer size and wraps modulo 2^32.
   function automatic logic [31:0] next_beat_addr(input logic [31:0] addr,
                                                  input logic [2:0]  size,
                                                  input logic [1:0]  burst);
      if (burst == BURST_FIXED) return addr;
      return addr + (32'd1 << size);
   endfunction

endpackage

// File: rtl/sram_word_mem.sv
// 32-bit word memory used as the slave's backing store.
//   clk   : clock, rising edge
//   we/be : write enable and per-byte enables
//   waddr/wdata : write word index and data
//   re/raddr    : read enable and word index
//   rdata       : registered read data; holds while re is low
// No reset: contents survive a bus reset. A read and a write of the same
// word in one cycle return the old contents.
module sram_word_mem #(
   parameter int DEPTH = 4096,
   parameter int IDX_W = 12
) (
   input  logic             clk,
   input  logic             we,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] waddr,
   input  logic [31:0]      wdata,
   input  logic             re,
   input  logic [IDX_W-1:0] raddr,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave in front of a single-port-per-direction word SRAM.
// The read and write engines are independent. Each engine handles one
// burst at a time.
//   aclk/aresetn          : clock and asynchronous active-low reset
//   ar*/r*                : read address and read data channels
//   aw*/w*/b*             : write address, write data and write response channels
//   *lock/*cache/*prot, wid : accepted but ignored
// Beats outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) return SLVERR.
// Out-of-range reads return zero data. Out-of-range writes are dropped.
module axi_sram_slave
   import axi_sram_slave_pkg::*;
#(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   function automatic logic addr_in_range(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      return 64'(off) < (64'(DEPTH_WORDS) * 64'd4);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
      return IDX_W'((addr - BASE_ADDR) >> 2);
   endfunction

   logic unused_inputs;
   assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

   // ---------------- read engine ----------------
   rd_state_e   rd_state_q, rd_state_d;
   logic [3:0]  rd_id_q;
   logic [31:0] rd_addr_q;
   logic [7:0]  rd_len_q, rd_beat_q;
   logic [2:0]  rd_size_q;
   logic [1:0]  rd_burst_q;
   logic        rd_inrange_p1;
   logic        ar_hs, r_hs, rd_last, rd_fetch_p0;
   logic [31:0] rd_next_addr, rd_addr_p0;
   logic [31:0] mem_rdata;

   assign ar_hs        = arvalid && arready;
   assign r_hs         = rvalid && rready;
   assign rd_last      = (rd_beat_q == rd_len_q);
   assign rd_next_addr = next_beat_addr(rd_addr_q, rd_size_q, rd_burst_q);
   // Fetch stage: the first beat is fetched on AR acceptance and each later
   // beat on the handshake of the one before it.
   assign rd_addr_p0   = (rd_state_q == R_IDLE) ? araddr : rd_next_addr;
   assign rd_fetch_p0  = ar_hs || (r_hs && !rd_last);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rd_state_q <= R_IDLE;
      else          rd_state_q <= rd_state_d;
   end

   always_comb begin
      rd_state_d = rd_state_q;
      case (rd_state_q)
         R_IDLE:  if (arvalid)            rd_state_d = R_DATA;
         R_DATA:  if (rready && rd_last)  rd_state_d = R_IDLE;
         default:                         rd_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      arready = (rd_state_q == R_IDLE);
      rvalid  = (rd_state_q == R_DATA);
      rid     = rd_id_q;
      rlast   = rvalid && rd_last;
      rresp   = (rvalid && !rd_inrange_p1) ? RESP_SLVERR : RESP_OKAY;
      rdata   = (rvalid && rd_inrange_p1) ? mem_rdata : 32'd0;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_id_q       <= '0;
         rd_beat_q     <= '0;
         rd_inrange_p1 <= 1'b0;
      end else begin
         if (ar_hs) rd_id_q <= arid;
         if (ar_hs)                   rd_beat_q <= '0;
         else if (r_hs && !rd_last)   rd_beat_q <= rd_beat_q + 8'd1;
         if (rd_fetch_p0) rd_inrange_p1 <= addr_in_range(rd_addr_p0);
      end
   end

   always_ff @(posedge aclk) begin
      if (ar_hs) begin
         rd_len_q   <= arlen;
         rd_size_q  <= arsize;
         rd_burst_q <= arburst;
      end
      if (rd_fetch_p0) rd_addr_q <= rd_addr_p0;
   end

   // ---------------- write engine ----------------
   wr_state_e   wr_state_q, wr_state_d;
   logic [3:0]  wr_id_q;
   logic [31:0] wr_addr_q;
   logic [7:0]  wr_len_q, wr_beat_q;
   logic [2:0]  wr_size_q;
   logic [1:0]  wr_burst_q;
   logic        wr_err_q;
   logic        aw_hs, w_hs, wr_last, wr_inrange;

   assign aw_hs      = awvalid && awready;
   assign w_hs       = wvalid && wready;
   assign wr_last    = (wr_beat_q == wr_len_q);
   assign wr_inrange = addr_in_range(wr_addr_q);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) wr_state_q <= W_IDLE;
      else          wr_state_q <= wr_state_d;
   end

   // The burst length from AW decides when the burst ends. wlast only
   // feeds the error flag.
   always_comb begin
      wr_state_d = wr_state_q;
      case (wr_state_q)
         W_IDLE:  if (awvalid)           wr_state_d = W_DATA;
         W_DATA:  if (wvalid && wr_last) wr_state_d = W_RESP;
         W_RESP:  if (bready)            wr_state_d = W_IDLE;
         default:                        wr_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      awready = (wr_state_q == W_IDLE);
      wready  = (wr_state_q == W_DATA);
      bvalid  = (wr_state_q == W_RESP);
      bid     = wr_id_q;
      bresp   = (bvalid && wr_err_q) ? RESP_SLVERR : RESP_OKAY;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_id_q   <= '0;
         wr_beat_q <= '0;
         wr_err_q  <= 1'b0;
      end else if (aw_hs) begin
         wr_id_q   <= awid;
         wr_beat_q <= '0;
         wr_err_q  <= 1'b0;
      end else if (w_hs) begin
         wr_beat_q <= wr_beat_q + 8'd1;
         wr_err_q  <= wr_err_q | !wr_inrange | (wlast != wr_last);
      end
   end

   always_ff @(posedge aclk) begin
      if (aw_hs) begin
         wr_len_q   <= awlen;
         wr_size_q  <= awsize;
         wr_burst_q <= awburst;
         wr_addr_q  <= awaddr;
      end else if (w_hs) begin
         wr_addr_q  <= next_beat_addr(wr_addr_q, wr_size_q, wr_burst_q);
      end
   end

   sram_word_mem #(
      .DEPTH (DEPTH_WORDS),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk   (aclk),
      .we    (w_hs && wr_inrange),
      .be    (wstrb),
      .waddr (word_idx(wr_addr_q)),
      .wdata (wdata),
      .re    (rd_fetch_p0 && addr_in_range(rd_addr_p0)),
      .raddr (word_idx(rd_addr_p0)),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave (128-word memory at address 0).
module tb_axi_sram_slave;
   import axi_sram_slave_pkg::*;

   localparam int          DEPTH = 128;
   localparam logic [31:0] BASE  = 32'h0;

   logic        aclk = 1'b0, aresetn = 1'b0;
   logic [3:0]  arid = '0, awid = '0, wid = '0, rid, bid;
   logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
   logic [7:0]  arlen = '0, awlen = '0;
   logic [2:0]  arsize = '0, awsize = '0, arprot = '0, awprot = '0;
   logic [1:0]  arburst = '0, awburst = '0, arlock = '0, awlock = '0, rresp, bresp;
   logic [3:0]  arcache = '0, awcache = '0, wstrb = '0;
   logic        arvalid = 0, arready, rlast, rvalid, rready = 0;
   logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;

   always #5 aclk = ~aclk;

   axi_sram_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rexp_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } bexp_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_rresp;
   } vec_t;

   rexp_t       rq [$];
   bexp_t       bq [$];
   logic [31:0] model [int];
   logic [31:0] wbuf [16];
   logic [3:0]  sbuf [16];
   vec_t        vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timed_out(input string name);
      total++;
      bad++;
      $display("FAIL %s: no handshake within cycle budget", name);
   endtask

   function automatic bit m_in_range(input logic [31:0] a);
      logic [31:0] o;
      o = a - BASE;
      return o < 32'(DEPTH * 4);
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic logic wl(input int i, input int len, input int mode);
      if (mode == 1) return (i == 0);
      if (mode == 2) return 1'b0;
      return (i == len);
   endfunction

   function automatic logic [31:0] step(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
      if (burst == 2'b00) return a;
      return a + (32'd1 << size);
   endfunction

   // Push the reference beats of a read burst, taken from the bench memory model.
   task automatic expect_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] a;
      rexp_t e;
      a = addr;
      for (int i = 0; i <= int'(len); i++) begin
         e.id   = id;
         e.last = (i == int'(len));
         if (m_in_range(a)) begin
            e.data = model.exists(m_idx(a)) ? model[m_idx(a)] : 32'hx;
            e.resp = 2'b00;
         end else begin
            e.data = 32'h0;
            e.resp = 2'b10;
         end
         rq.push_back(e);
         a = step(a, size, burst);
      end
   endtask

   task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int wlast_mode);
      logic [31:0] a, tmp;
      bit err;
      bexp_t e;
      int n;
      a = addr;
      err = 0;
      for (int i = 0; i <= int'(len); i++) begin
         if (!m_in_range(a)) err = 1;
         else begin
            tmp = model.exists(m_idx(a)) ? model[m_idx(a)] : 32'hx;
            for (int b = 0; b < 4; b++) if (sbuf[i][b]) tmp[8*b +: 8] = wbuf[i][8*b +: 8];
            model[m_idx(a)] = tmp;
         end
         if (wl(i, int'(len), wlast_mode) != (i == int'(len))) err = 1;
         a = step(a, size, burst);
      end
      e.id = id;
      e.resp = err ? 2'b10 : 2'b00;
      bq.push_back(e);

      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1;
      n = 0;
      while (!awready && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) timed_out("aw_accept");
      @(negedge aclk);
      awvalid = 0;
      for (int i = 0; i <= int'(len); i++) begin
         wdata = wbuf[i]; wstrb = sbuf[i]; wlast = wl(i, int'(len), wlast_mode); wvalid = 1;
         n = 0;
         while (!wready && n < 50) begin @(negedge aclk); n++; end
         if (n >= 50) timed_out("w_beat");
         @(negedge aclk);
      end
      wvalid = 0; wlast = 0; bready = 1;
      n = 0;
      while (!bvalid && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) timed_out("b_resp");
      e = bq.pop_front();
      check("bid", 64'(bid), 64'(e.id));
      check("bresp", 64'(bresp), 64'(e.resp));
      @(negedge aclk);
      bready = 0;
   endtask

   // pat gives rready per cycle (bit c%4). abort_at >= 0 pulls reset
   // while that beat is being presented.
   task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [3:0] pat,
                             input int abort_at);
      int n, beats, c;
      bit stalled;
      rexp_t held, cur, e;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1;
      n = 0;
      while (!arready && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) timed_out("ar_accept");
      @(negedge aclk);
      arvalid = 0;
      check("rvalid_latency", 64'(rvalid), 64'd1);
      beats = 0; c = 0; stalled = 0; held = '0;
      while (beats <= int'(len) && c < 200) begin
         if (beats == abort_at) begin
            aresetn = 0;
            #1;
            check("rst_mid_rvalid", 64'(rvalid), 64'd0);
            check("rst_mid_ready", 64'({arready, awready, wready, bvalid}), 64'b1100);
            check("rst_mid_rout", 64'({rid, rdata, rresp, rlast}), 64'd0);
            rq.delete();
            rready = 0;
            @(negedge aclk);
            aresetn = 1;
            @(negedge aclk);
            return;
         end
         rready = pat[c % 4];
         cur = {rid, rdata, rresp, rlast};
         if (rvalid) begin
            if (stalled) check("r_stall_stable", 64'(cur), 64'(held));
            if (rready) begin
               e = rq.pop_front();
               check("r_beat", 64'(cur), 64'(e));
               beats++;
               stalled = 0;
            end else begin
               held = cur;
               stalled = 1;
            end
         end
         c++;
         @(negedge aclk);
      end
      rready = 0;
      if (beats <= int'(len)) timed_out("r_beats");
      check("r_done_idle", 64'({rvalid, arready}), 64'b01);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rexp_t e;
      for (int i = 0; i < 16; i++) begin wbuf[i] = '0; sbuf[i] = 4'hF; end

      vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'h0000_0000, RESP_OKAY};
      vecs[1] = '{1'b1, 32'h0000_0000, 32'hAABB_CCDD, 4'b0101, 32'h00BB_00DD, RESP_OKAY};
      vecs[2] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, RESP_OKAY};
      vecs[3] = '{1'b1, 32'h0000_0013, 32'h1122_3344, 4'b1000, 32'h11AD_BEEF, RESP_OKAY};
      vecs[4] = '{1'b1, 32'h0000_01FC, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, RESP_OKAY};
      vecs[5] = '{1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, 32'h0000_0000, RESP_SLVERR};
      vecs[6] = '{1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 4'hF, 32'h0000_0000, RESP_SLVERR};
      vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h00BB_00DD, RESP_OKAY};
      vecs[8] = '{1'b0, 32'h0000_01FC, 32'h0,         4'h0, 32'hCAFE_F00D, RESP_OKAY};

      // reset state
      #12;
      check("rst_ready", 64'({arready, awready, wready, rvalid, bvalid, rlast}), 64'b110000);
      check("rst_rout", 64'({rid, rdata, rresp}), 64'd0);
      check("rst_bout", 64'({bid, bresp}), 64'd0);
      @(negedge aclk);
      aresetn = 1;
      @(negedge aclk);

      // table: single-beat write then single-beat read
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].wr) begin
            wbuf[0] = vecs[i].wdata;
            sbuf[0] = vecs[i].wstrb;
            write_burst(4'(i + 1), vecs[i].addr, 8'd0, 3'd2, BURST_INCR, 0);
         end
         e.id = 4'(i + 2); e.data = vecs[i].exp_rdata; e.resp = vecs[i].exp_rresp; e.last = 1'b1;
         rq.push_back(e);
         read_burst(4'(i + 2), vecs[i].addr, 8'd0, 3'd2, BURST_INCR, 4'hF, -1);
      end
      for (int i = 0; i < 16; i++) sbuf[i] = 4'hF;

      // INCR burst write 1..4 then read back
      for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
      write_burst(4'd5, 32'h100, 8'd3, 3'd2, BURST_INCR, 0);
      expect_read(4'd6, 32'h100, 8'd3, 3'd2, BURST_INCR);
      read_burst(4'd6, 32'h100, 8'd3, 3'd2, BURST_INCR, 4'hF, -1);
      // FIXED, WRAP-as-INCR and byte-size INCR
      expect_read(4'd7, 32'h10, 8'd2, 3'd2, BURST_FIXED);
      read_burst(4'd7, 32'h10, 8'd2, 3'd2, BURST_FIXED, 4'hF, -1);
      expect_read(4'd8, 32'h104, 8'd1, 3'd2, BURST_WRAP);
      read_burst(4'd8, 32'h104, 8'd1, 3'd2, BURST_WRAP, 4'hF, -1);
      expect_read(4'd9, 32'h100, 8'd3, 3'd0, BURST_INCR);
      read_burst(4'd9, 32'h100, 8'd3, 3'd0, BURST_INCR, 4'hF, -1);
      // rready toggled 1,0,0,1
      expect_read(4'd10, 32'h100, 8'd3, 3'd2, BURST_INCR);
      read_burst(4'd10, 32'h100, 8'd3, 3'd2, BURST_INCR, 4'b1001, -1);

      // wlast misplaced / missing, and a burst running off the end of memory
      wbuf[0] = 32'h10; wbuf[1] = 32'h20;
      write_burst(4'd11, 32'h180, 8'd1, 3'd2, BURST_INCR, 1);
      wbuf[0] = 32'h30;
      write_burst(4'd12, 32'h188, 8'd0, 3'd2, BURST_INCR, 2);
      expect_read(4'd11, 32'h180, 8'd2, 3'd2, BURST_INCR);
      read_burst(4'd11, 32'h180, 8'd2, 3'd2, BURST_INCR, 4'hF, -1);
      wbuf[0] = 32'hA1; wbuf[1] = 32'hA2;
      write_burst(4'd13, 32'h1FC, 8'd1, 3'd2, BURST_INCR, 0);
      expect_read(4'd13, 32'h1FC, 8'd1, 3'd2, BURST_INCR);
      read_burst(4'd13, 32'h1FC, 8'd1, 3'd2, BURST_INCR, 4'hF, -1);

      // AR and AW in the same cycle
      arid = 4'd3; araddr = 32'h100; arlen = 0; arsize = 3'd2; arburst = BURST_INCR; arvalid = 1;
      awid = 4'd4; awaddr = 32'h104; awlen = 0; awsize = 3'd2; awburst = BURST_INCR; awvalid = 1;
      check("arw_same_ready", 64'({arready, awready}), 64'b11);
      @(negedge aclk);
      arvalid = 0; awvalid = 0;
      check("arw_same_busy", 64'({rvalid, wready, arready, awready}), 64'b1100);
      check("arw_same_rdata", 64'({rid, rdata, rlast}), 64'({4'd3, 32'd1, 1'b1}));
      rready = 1; wdata = 32'h55; wstrb = 4'hF; wlast = 1; wvalid = 1;
      @(negedge aclk);
      rready = 0; wvalid = 0; wlast = 0; bready = 1;
      check("arw_same_b", 64'({bvalid, bid, bresp}), 64'({1'b1, 4'd4, 2'b00}));
      @(negedge aclk);
      bready = 0;
      model[m_idx(32'h104)] = 32'h55;

      // read fetch and write to the same word in one cycle return old data
      awid = 4'd1; awaddr = 32'h100; awlen = 0; awsize = 3'd2; awburst = BURST_INCR; awvalid = 1;
      @(negedge aclk);
      awvalid = 0;
      arid = 4'd2; araddr = 32'h100; arlen = 0; arvalid = 1;
      wdata = 32'h77; wstrb = 4'hF; wlast = 1; wvalid = 1;
      check("rbw_ready", 64'({arready, wready}), 64'b11);
      @(negedge aclk);
      arvalid = 0; wvalid = 0; wlast = 0;
      check("rbw_old_data", 64'({rvalid, rdata}), 64'({1'b1, 32'd1}));
      rready = 1; bready = 1;
      @(negedge aclk);
      rready = 0; bready = 0;
      model[m_idx(32'h100)] = 32'h77;
      expect_read(4'd2, 32'h100, 8'd1, 3'd2, BURST_INCR);
      read_burst(4'd2, 32'h100, 8'd1, 3'd2, BURST_INCR, 4'hF, -1);

      // reset during beat 2 of a len-7 read, then a normal read
      expect_read(4'd14, 32'h100, 8'd7, 3'd2, BURST_INCR);
      read_burst(4'd14, 32'h100, 8'd7, 3'd2, BURST_INCR, 4'hF, 2);
      expect_read(4'd15, 32'h100, 8'd3, 3'd2, BURST_INCR);
      read_burst(4'd15, 32'h100, 8'd3, 3'd2, BURST_INCR, 4'hF, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
